// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared state encodings and width helper for the scanned
//               button debounce controller and its timing sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Per-channel debounce state; the two IDLE states hold an accepted level,
    // the two WAIT states are qualifying a candidate new level.
    typedef enum logic [1:0] {
        ST_IDLE_LO = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_IDLE_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } deb_state_t;

    // Bits needed to hold values 0..x-1, never less than one bit.
    function automatic int width_of(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divider that emits a one-cycle tick every
//               TICK_DIV enabled clocks. Frozen while en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);
    import debounce_pkg::*;

    localparam int                 c_cnt_w = width_of(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Count 0..TICK_DIV-1 on enabled cycles, wrapping to zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    // Tick marks the wrap cycle, so it only fires while running.
    assign tick = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : debounce_scan_ctrl
// Description : Time-multiplexed debouncer. One debounce datapath and one
//               prescaler are shared round-robin across N_CH buttons; the
//               per-channel state lives in small register arrays.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_scan_ctrl #(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 20
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       en,
    input  logic [N_CH-1:0]                            noisy,
    output logic [N_CH-1:0]                            debounced,
    output logic [N_CH-1:0]                            rise,
    output logic [N_CH-1:0]                            fall,
    output logic [debounce_pkg::width_of(N_CH)-1:0]    scan_idx
);
    import debounce_pkg::*;

    localparam int                 c_idx_w    = width_of(N_CH);
    localparam int                 c_cnt_w    = width_of(STABLE_TICKS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_CH - 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(STABLE_TICKS - 1);

    // Parameter sanity: the scan must visit every channel within one tick.
    if (N_CH < 1) begin : g_bad_n_ch
        $error("debounce_scan_ctrl: N_CH must be >= 1");
    end
    if (TICK_DIV < N_CH) begin : g_bad_tick_div
        $error("debounce_scan_ctrl: TICK_DIV must be >= N_CH");
    end
    if (STABLE_TICKS < 2) begin : g_bad_stable
        $error("debounce_scan_ctrl: STABLE_TICKS must be >= 2");
    end

    logic [N_CH-1:0]    r_sync1;
    logic [N_CH-1:0]    r_sync2;
    deb_state_t         r_state [N_CH];
    logic [c_cnt_w-1:0] r_count [N_CH];
    logic [N_CH-1:0]    r_pending;
    logic [c_idx_w-1:0] r_scan_idx;
    logic [N_CH-1:0]    r_debounced;
    logic [N_CH-1:0]    r_rise;
    logic [N_CH-1:0]    r_fall;

    logic               w_tick;
    logic               w_in;
    deb_state_t         w_state;
    logic [c_cnt_w-1:0] w_count;
    logic               w_pend;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .tick    (w_tick)
    );

    // Views of the channel currently under the scan pointer.
    assign w_in    = r_sync2[r_scan_idx];
    assign w_state = r_state[r_scan_idx];
    assign w_count = r_count[r_scan_idx];
    assign w_pend  = r_pending[r_scan_idx];

    // Two-flop synchronizer; runs regardless of en so inputs stay fresh.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= noisy;
            r_sync2 <= r_sync1;
        end
    end

    // Scan pointer, pending ticks and the shared debounce FSM for the visited channel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= ST_IDLE_LO;
                r_count[i] <= '0;
            end
            r_pending   <= '0;
            r_scan_idx  <= '0;
            r_debounced <= '0;
            r_rise      <= '0;
            r_fall      <= '0;
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            if (en) begin
                r_scan_idx <= (r_scan_idx == c_last_idx) ? '0 : r_scan_idx + 1'b1;

                // A fresh tick outranks the clear from this visit, so the
                // visited channel keeps the new tick for its next visit.
                if (w_tick) begin
                    r_pending <= '1;
                end else begin
                    r_pending[r_scan_idx] <= 1'b0;
                end

                case (w_state)
                    ST_IDLE_LO: begin
                        if (w_in) begin
                            r_state[r_scan_idx] <= ST_WAIT_HI;
                            r_count[r_scan_idx] <= '0;
                        end
                    end
                    ST_WAIT_HI: begin
                        if (!w_in) begin
                            r_state[r_scan_idx] <= ST_IDLE_LO;
                            r_count[r_scan_idx] <= '0;
                        end else if (w_pend) begin
                            if (w_count == c_last_cnt) begin
                                r_state[r_scan_idx]     <= ST_IDLE_HI;
                                r_count[r_scan_idx]     <= '0;
                                r_rise[r_scan_idx]      <= 1'b1;
                                r_debounced[r_scan_idx] <= 1'b1;
                            end else begin
                                r_count[r_scan_idx] <= w_count + 1'b1;
                            end
                        end
                    end
                    ST_IDLE_HI: begin
                        if (!w_in) begin
                            r_state[r_scan_idx] <= ST_WAIT_LO;
                            r_count[r_scan_idx] <= '0;
                        end
                    end
                    ST_WAIT_LO: begin
                        if (w_in) begin
                            r_state[r_scan_idx] <= ST_IDLE_HI;
                            r_count[r_scan_idx] <= '0;
                        end else if (w_pend) begin
                            if (w_count == c_last_cnt) begin
                                r_state[r_scan_idx]     <= ST_IDLE_LO;
                                r_count[r_scan_idx]     <= '0;
                                r_fall[r_scan_idx]      <= 1'b1;
                                r_debounced[r_scan_idx] <= 1'b0;
                            end else begin
                                r_count[r_scan_idx] <= w_count + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state[r_scan_idx] <= ST_IDLE_LO;
                        r_count[r_scan_idx] <= '0;
                    end
                endcase
            end
        end
    end

    assign debounced = r_debounced;
    assign rise      = r_rise;
    assign fall      = r_fall;
    assign scan_idx  = r_scan_idx;

endmodule
`default_nettype wire
